// File: rtl/filtr_sched_pkg.sv
// Shared definitions for the filtr_a sequencer: pass timing defaults,
// scheduler state encoding and the channel index width.
package filtr_sched_pkg;

  localparam int FILT_CYC_DEF = 6;
  localparam int DONE_TMO_DEF = 2;
  localparam int CH_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAPT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/filtr_sched_rr_pick.sv
// Combinational round-robin picker: grants the first requester strictly after
// ptr, wrapping N-1 -> 0, so ptr itself is considered last.
import filtr_sched_pkg::*;

module rr_pick #(
  parameter int N  = 2,
  parameter int IW = CH_W
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Walk offsets from farthest to nearest so the nearest requester after ptr
  // is the last one written and therefore wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int off = N; off >= 1; off--) begin
      for (int c = 0; c < N; c++) begin
        if ((c == ((int'(ptr) + off) % N)) && req[c]) begin
          gnt     = '0;
          gnt[c]  = 1'b1;
          gnt_idx = IW'(c);
          any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/filtr_sched.sv
// Round-robin sequencer driving NCH filtr_a instances: buffers one sample per
// channel, runs one filter pass at a time and merges results onto one stream.
import filtr_sched_pkg::*;

module filtr_sched #(
  parameter int NCH       = 2,
  parameter int DATA_SIZE = 24,
  parameter int FILT_CYC  = FILT_CYC_DEF,
  parameter int DONE_TMO  = DONE_TMO_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [NCH-1:0]           in_valid,
  input  logic [NCH*DATA_SIZE-1:0] in_data,
  output logic [NCH-1:0]           flt_trig,
  output logic [NCH*DATA_SIZE-1:0] flt_data_in,
  input  logic [NCH-1:0]           flt_done,
  input  logic [NCH*DATA_SIZE-1:0] flt_data_out,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_SIZE-1:0]     out_data,
  output logic [NCH-1:0]           overrun,
  output logic [NCH-1:0]           done_err,
  input  logic                     clr_flags,
  output logic                     busy
);

  localparam int CNT_W = $clog2(FILT_CYC + 1) + 1;

  sched_state_t         state;
  logic [NCH-1:0]       pend;
  logic [DATA_SIZE-1:0] pend_reg [NCH];
  logic [DATA_SIZE-1:0] hold     [NCH];
  logic [CH_W-1:0]      rr_ptr;
  logic [CH_W-1:0]      cur;
  logic [NCH-1:0]       cur_oh;
  logic [CNT_W-1:0]     cnt;
  logic                 done_seen;

  logic [NCH-1:0]       gnt;
  logic [CH_W-1:0]      gnt_idx;
  logic                 any_pend;
  logic                 take;
  logic [NCH-1:0]       take_vec;
  logic [NCH-1:0]       ovr_set;
  logic                 derr_set;
  logic                 cur_done;
  logic [DATA_SIZE-1:0] cur_data;

  rr_pick #(.N(NCH), .IW(CH_W)) u_pick (
    .req     (pend),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_pend)
  );

  // A sample arriving in the same cycle its slot is consumed refills the slot
  // instead of counting as an overrun.
  always_comb begin
    take     = (state == ST_IDLE) && en && any_pend;
    take_vec = take ? gnt : '0;
    ovr_set  = in_valid & pend & ~take_vec;
    cur_done = |(flt_done & cur_oh);
    cur_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cur_oh[c]) cur_data = flt_data_out[c*DATA_SIZE +: DATA_SIZE];
    end
    derr_set = (state == ST_WAIT) && (cnt == CNT_W'(DONE_TMO - 1)) &&
               !done_seen && !cur_done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= '0;
      overrun <= '0;
      for (int c = 0; c < NCH; c++) begin
        pend_reg[c] <= '0;
        hold[c]     <= '0;
      end
    end else begin
      overrun <= (overrun & ~{NCH{clr_flags}}) | ovr_set;
      for (int c = 0; c < NCH; c++) begin
        if (take_vec[c]) begin
          hold[c] <= pend_reg[c];
          pend[c] <= in_valid[c];
          if (in_valid[c]) pend_reg[c] <= in_data[c*DATA_SIZE +: DATA_SIZE];
        end else if (in_valid[c] && !pend[c]) begin
          pend_reg[c] <= in_data[c*DATA_SIZE +: DATA_SIZE];
          pend[c]     <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_hold
    assign flt_data_in[g*DATA_SIZE +: DATA_SIZE] = hold[g];
  end

  // Pass sequencing: the counter starts in the first WAIT cycle, so leaving
  // at FILT_CYC-2 puts out_valid exactly FILT_CYC cycles after the trigger.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      flt_trig  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      cur       <= '0;
      cur_oh    <= '0;
      rr_ptr    <= CH_W'(NCH - 1);
      cnt       <= '0;
      done_seen <= 1'b0;
      done_err  <= '0;
    end else begin
      flt_trig  <= '0;
      out_valid <= 1'b0;
      done_err  <= (done_err & ~{NCH{clr_flags}}) | (derr_set ? cur_oh : '0);
      case (state)
        ST_IDLE: begin
          if (take) begin
            state     <= ST_TRIG;
            flt_trig  <= gnt;
            cur       <= gnt_idx;
            cur_oh    <= gnt;
            cnt       <= '0;
            busy      <= 1'b1;
            done_seen <= 1'b0;
          end
        end
        ST_TRIG: begin
          state     <= ST_WAIT;
          cnt       <= '0;
          done_seen <= cur_done;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cur_done) done_seen <= 1'b1;
          if (cnt == CNT_W'(FILT_CYC - 2)) begin
            state     <= ST_CAPT;
            out_valid <= 1'b1;
            out_ch    <= cur;
            out_data  <= cur_data;
          end
        end
        ST_CAPT: begin
          rr_ptr <= cur;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filtr_sched.sv
// Directed bench for filtr_sched with two behavioural filtr_a models
// (data_out = data_in + 1, filter_done in S1, optional done suppression).
module tb_filtr_sched;
  import filtr_sched_pkg::*;

  localparam int NCH = 2;
  localparam int DS  = 24;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DS-1:0] in_data;
  logic [NCH-1:0]    flt_trig;
  logic [NCH*DS-1:0] flt_data_in;
  logic [NCH-1:0]    flt_done;
  logic [NCH*DS-1:0] flt_data_out;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [DS-1:0]     out_data;
  logic [NCH-1:0]    overrun;
  logic [NCH-1:0]    done_err;
  logic              clr_flags;
  logic              busy;
  logic              suppress_done;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  filtr_sched #(.NCH(NCH), .DATA_SIZE(DS), .FILT_CYC(6), .DONE_TMO(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .flt_trig     (flt_trig),
    .flt_data_in  (flt_data_in),
    .flt_done     (flt_done),
    .flt_data_out (flt_data_out),
    .out_valid    (out_valid),
    .out_ch       (out_ch),
    .out_data     (out_data),
    .overrun      (overrun),
    .done_err     (done_err),
    .clr_flags    (clr_flags),
    .busy         (busy)
  );

  // Filter model: active-high reset, S1..S5 after the trigger cycle.
  logic [2:0]    mst   [NCH];
  logic [DS-1:0] mdout [NCH];

  always_ff @(posedge clk or posedge (~reset_n)) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        mst[c]   <= '0;
        mdout[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (flt_trig[c]) begin
          mst[c]   <= 3'd1;
          mdout[c] <= flt_data_in[c*DS +: DS] + 1'b1;
        end else if (mst[c] != 3'd0) begin
          mst[c] <= (mst[c] == 3'd5) ? 3'd0 : mst[c] + 3'd1;
        end
      end
    end
  end

  always_comb begin
    flt_done     = '0;
    flt_data_out = '0;
    for (int c = 0; c < NCH; c++) begin
      flt_done[c]              = (mst[c] == 3'd1) && !suppress_done;
      flt_data_out[c*DS +: DS] = mdout[c];
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [NCH-1:0] mask, input logic [DS-1:0] d0,
                                input logic [DS-1:0] d1);
    in_valid = mask;
    in_data  = {d1, d0};
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [CH_W-1:0] ch, input logic [DS-1:0] d);
    check_output({tag, "_valid"}, 32'(out_valid), 32'h1);
    check_output({tag, "_ch"},    32'(out_ch),    32'(ch));
    check_output({tag, "_data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    bit saw_valid;
    bit saw_trig;
    reset_n       = 1'b0;
    en            = 1'b1;
    in_valid      = '0;
    in_data       = '0;
    clr_flags     = 1'b0;
    suppress_done = 1'b0;
    step(2);
    check_output("rst_trig",     32'(flt_trig),    32'h0);
    check_output("rst_valid",    32'(out_valid),   32'h0);
    check_output("rst_busy",     32'(busy),        32'h0);
    check_output("rst_flags",    32'({overrun, done_err}), 32'h0);
    check_output("rst_hold",     32'(flt_data_in[31:0]), 32'h0);
    reset_n = 1'b1;
    step(1);

    $display("[TB] single sample on ch0");
    apply_stimulus(2'b01, 24'h000100, 24'h0);
    check_output("t1_no_trig_yet", 32'(flt_trig), 32'h0);
    step(1);
    check_output("t1_trig",  32'(flt_trig), 32'h1);
    check_output("t1_hold",  32'(flt_data_in[DS-1:0]), 32'h000100);
    check_output("t1_busy",  32'(busy), 32'h1);
    step(1);
    check_output("t1_trig_pulse", 32'(flt_trig), 32'h0);
    step(4);
    check_output("t1_early_valid", 32'(out_valid), 32'h0);
    step(1);
    check_result("t1", 3'd0, 24'h000101);
    step(1);
    check_output("t1_valid_pulse", 32'(out_valid), 32'h0);
    check_output("t1_idle_busy",   32'(busy), 32'h0);

    $display("[TB] simultaneous samples, round-robin order");
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    apply_stimulus(2'b11, 24'h000010, 24'h000020);
    step(1);
    check_output("t2_trig_a", 32'(flt_trig), 32'h1);
    step(6);
    check_result("t2_a", 3'd0, 24'h000011);
    step(2);
    check_output("t2_trig_b", 32'(flt_trig), 32'h2);
    check_output("t2_hold_b", 32'(flt_data_in[2*DS-1:DS]), 32'h000020);
    step(6);
    check_result("t2_b", 3'd1, 24'h000021);
    apply_stimulus(2'b11, 24'h000030, 24'h000040);
    step(1);
    check_output("t2_trig_c", 32'(flt_trig), 32'h1);
    check_output("t2_no_ovr", 32'(overrun),  32'h0);
    step(6);
    check_result("t2_c", 3'd0, 24'h000031);
    step(2);
    check_output("t2_trig_d", 32'(flt_trig), 32'h2);
    step(6);
    check_result("t2_d", 3'd1, 24'h000041);
    step(1);

    $display("[TB] overrun on ch0");
    apply_stimulus(2'b01, 24'h000500, 24'h0);
    step(1);
    check_output("t3_trig", 32'(flt_trig), 32'h1);
    apply_stimulus(2'b01, 24'h000600, 24'h0);
    check_output("t3_no_ovr_first", 32'(overrun), 32'h0);
    step(1);
    apply_stimulus(2'b01, 24'h000700, 24'h0);
    step(1);
    apply_stimulus(2'b01, 24'h000800, 24'h0);
    check_output("t3_ovr", 32'(overrun), 32'h1);
    step(1);
    check_result("t3_a", 3'd0, 24'h000501);
    step(2);
    check_output("t3_trig_kept", 32'(flt_trig), 32'h1);
    check_output("t3_hold_kept", 32'(flt_data_in[DS-1:0]), 32'h000600);
    step(6);
    check_result("t3_b", 3'd0, 24'h000601);
    check_output("t3_ovr_sticky", 32'(overrun), 32'h1);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check_output("t3_ovr_clr", 32'(overrun), 32'h0);

    $display("[TB] missing filter_done");
    suppress_done = 1'b1;
    apply_stimulus(2'b01, 24'h000800, 24'h0);
    step(1);
    check_output("t4_trig", 32'(flt_trig), 32'h1);
    step(1);
    check_output("t4_derr_early", 32'(done_err), 32'h0);
    step(2);
    check_output("t4_derr", 32'(done_err), 32'h1);
    step(3);
    check_result("t4", 3'd0, 24'h000801);
    suppress_done = 1'b0;
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check_output("t4_derr_clr", 32'(done_err), 32'h0);

    $display("[TB] enable stall with ch1 pending");
    apply_stimulus(2'b01, 24'h000900, 24'h0);
    step(1);
    check_output("t5_trig_a", 32'(flt_trig), 32'h1);
    apply_stimulus(2'b10, 24'h0, 24'h000A00);
    en        = 1'b0;
    clr_flags = 1'b1;
    apply_stimulus(2'b10, 24'h0, 24'h000B00);
    clr_flags = 1'b0;
    check_output("t5_set_beats_clr", 32'(overrun), 32'h2);
    step(4);
    check_result("t5_a", 3'd0, 24'h000901);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_output("t5_stalled", 32'(flt_trig), 32'h0);
    end
    en = 1'b1;
    step(1);
    check_output("t5_trig_b", 32'(flt_trig), 32'h2);
    check_output("t5_hold_b", 32'(flt_data_in[2*DS-1:DS]), 32'h000A00);
    step(6);
    check_result("t5_b", 3'd1, 24'h000A01);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;

    $display("[TB] reset during a pass");
    apply_stimulus(2'b01, 24'h000C00, 24'h0);
    step(1);
    check_output("t6_trig", 32'(flt_trig), 32'h1);
    step(2);
    #2 reset_n = 1'b0;
    #1;
    check_output("t6_rst_busy",  32'(busy),      32'h0);
    check_output("t6_rst_valid", 32'(out_valid), 32'h0);
    check_output("t6_rst_hold",  32'(flt_data_in[DS-1:0]), 32'h0);
    @(negedge clk);
    reset_n   = 1'b1;
    saw_valid = 1'b0;
    saw_trig  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (out_valid) saw_valid = 1'b1;
      if (|flt_trig) saw_trig = 1'b1;
    end
    check_output("t6_no_valid_after", 32'(saw_valid), 32'h0);
    check_output("t6_pend_lost",      32'(saw_trig),  32'h0);
    apply_stimulus(2'b01, 24'h000D00, 24'h0);
    step(1);
    check_output("t6_trig_new", 32'(flt_trig), 32'h1);
    step(6);
    check_result("t6_new", 3'd0, 24'h000D01);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
